cordic_seq_ctrl: RTL

CORDIC_SEQ_CTRL -- requirements
Module: cordic_seq_ctrl

---
 rtl/cordic_pkg.sv | 40 ++++
 rtl/cordic_iter_stage.sv | 33 +++
 rtl/cordic_seq_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: Q2.15 format, gain constant, FSM encoding and atan table.
package cordic_pkg;

  localparam int          Q_FRAC_BITS  = 15;
  localparam int          Q_ONE        = 32768;
  localparam int          ATAN_ENTRIES = 16;
  localparam logic [15:0] K_GAIN       = 16'd19898;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_COMP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // atan(2^-k) in Q2.15, rounded to nearest
  function automatic logic [15:0] atan_lut(input logic [3:0] k);
    logic [15:0] a;
    case (k)
      4'd0:    a = 16'd25736;
      4'd1:    a = 16'd15193;
      4'd2:    a = 16'd8027;
      4'd3:    a = 16'd4075;
      4'd4:    a = 16'd2045;
      4'd5:    a = 16'd1024;
      4'd6:    a = 16'd512;
      4'd7:    a = 16'd256;
      4'd8:    a = 16'd128;
      4'd9:    a = 16'd64;
      4'd10:   a = 16'd32;
      4'd11:   a = 16'd16;
      4'd12:   a = 16'd8;
      4'd13:   a = 16'd4;
      4'd14:   a = 16'd2;
      default: a = 16'd1;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cordic_iter_stage.sv
// Combinational CORDIC micro-rotation with runtime shift amount and elementary angle.
module cordic_iter_stage #(
  parameter int DATA_OP_WIDTH = 18
) (
  input  logic signed [DATA_OP_WIDTH-1:0] x_i,
  input  logic signed [DATA_OP_WIDTH-1:0] y_i,
  input  logic signed [DATA_OP_WIDTH-1:0] z_i,
  input  logic        [3:0]               shift_i,
  input  logic signed [DATA_OP_WIDTH-1:0] angle_i,
  input  logic                            sigma_i,
  output logic signed [DATA_OP_WIDTH-1:0] x_o,
  output logic signed [DATA_OP_WIDTH-1:0] y_o,
  output logic signed [DATA_OP_WIDTH-1:0] z_o
);

  logic signed [DATA_OP_WIDTH-1:0] x_sh;
  logic signed [DATA_OP_WIDTH-1:0] y_sh;

  always_comb begin
    x_sh = x_i >>> shift_i;
    y_sh = y_i >>> shift_i;
    if (sigma_i) begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + angle_i;
    end else begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - angle_i;
    end
  end

endmodule

// File: rtl/cordic_seq_ctrl.sv
// Iterative CORDIC sequencer: one shared micro-rotation stage, one rotation per cycle.
// Optional gain compensation state enabled by macro CORDIC_SEQ_GAIN_COMP_EN.
//   state | meaning
//   IDLE  | ready for a request
//   ITER  | micro-rotation k per cycle
//   COMP  | scale x/y by K (compensated build only)
//   DONE  | result held until consumer takes it
module cordic_seq_ctrl
  import cordic_pkg::*;
#(
  parameter int NUM_ITER      = 12,
  parameter int FUNC_WIDTH    = 1,
  parameter int DATA_OP_WIDTH = 18
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic        [FUNC_WIDTH-1:0]    i_func,
  input  logic signed [DATA_OP_WIDTH-1:0] i_x,
  input  logic signed [DATA_OP_WIDTH-1:0] i_y,
  input  logic signed [DATA_OP_WIDTH-1:0] i_z,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic signed [DATA_OP_WIDTH-1:0] o_x,
  output logic signed [DATA_OP_WIDTH-1:0] o_y,
  output logic signed [DATA_OP_WIDTH-1:0] o_z,
  output logic                            o_busy
);

  localparam int         W      = DATA_OP_WIDTH;
  localparam logic [3:0] K_LAST = 4'(NUM_ITER - 1);

  state_e                 state_q;
  logic [3:0]             k_q;
  logic [FUNC_WIDTH-1:0]  func_q;
  logic signed [W-1:0]    x_q, y_q, z_q;
  logic signed [W-1:0]    ox_q, oy_q, oz_q;
  logic                   valid_q, ready_q, busy_q;

  logic signed [W-1:0]    angle;
  logic                   sigma;
  logic signed [W-1:0]    x_d, y_d, z_d;

  assign angle = {{(W-16){1'b0}}, atan_lut(k_q)};
  assign sigma = (func_q == FUNC_WIDTH'(1)) ? ~y_q[W-1] : z_q[W-1];

  cordic_iter_stage #(.DATA_OP_WIDTH(W)) u_stage (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .shift_i (k_q),
    .angle_i (angle),
    .sigma_i (sigma),
    .x_o     (x_d),
    .y_o     (y_d),
    .z_o     (z_d)
  );

`ifdef CORDIC_SEQ_GAIN_COMP_EN
  logic signed [W+16:0] x_prod, y_prod;
  logic signed [W-1:0]  x_comp, y_comp;
  assign x_prod = x_q * $signed({1'b0, K_GAIN});
  assign y_prod = y_q * $signed({1'b0, K_GAIN});
  assign x_comp = W'(x_prod >>> Q_FRAC_BITS);
  assign y_comp = W'(y_prod >>> Q_FRAC_BITS);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      func_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      oz_q    <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid && ready_q) begin
            func_q  <= i_func;
            x_q     <= i_x;
            y_q     <= i_y;
            z_q     <= i_z;
            k_q     <= '0;
            state_q <= ST_ITER;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_ITER: begin
          x_q <= x_d;
          y_q <= y_d;
          z_q <= z_d;
          k_q <= k_q + 4'd1;
          if (k_q == K_LAST) begin
            k_q <= '0;
`ifdef CORDIC_SEQ_GAIN_COMP_EN
            state_q <= ST_COMP;
`else
            state_q <= ST_DONE;
            ox_q    <= x_d;
            oy_q    <= y_d;
            oz_q    <= z_d;
            valid_q <= 1'b1;
`endif
          end
        end
`ifdef CORDIC_SEQ_GAIN_COMP_EN
        ST_COMP: begin
          x_q     <= x_comp;
          y_q     <= y_comp;
          ox_q    <= x_comp;
          oy_q    <= y_comp;
          oz_q    <= z_q;
          valid_q <= 1'b1;
          state_q <= ST_DONE;
        end
`endif
        ST_DONE: begin
          if (i_ready) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_x     = ox_q;
  assign o_y     = oy_q;
  assign o_z     = oz_q;

endmodule
